// File: rtl/ipm_bus_pkg.sv
// Shared definitions for the ipm 8-bit MCU bus: command opcodes, register map
// defaults and the initiator FSM state encoding.
package ipm_bus_pkg;

    typedef enum logic [1:0] {
        OP_WRITE_WORD = 2'b00,
        OP_READ_WORD  = 2'b01,
        OP_WRITE_CONF = 2'b10,
        OP_START      = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } bus_state_e;

    localparam logic [3:0] ADDR_DATA_DEF  = 4'h0;
    localparam logic [3:0] ADDR_CONF_DEF  = 4'h4;
    localparam logic [3:0] ADDR_START_DEF = 4'h5;
    localparam logic [7:0] START_BYTE     = 8'h01;

    function automatic logic op_is_word(input logic [1:0] op);
        return (op == OP_WRITE_WORD) || (op == OP_READ_WORD);
    endfunction

endpackage

// File: rtl/ipm_sync2.sv
// Two-flop synchroniser for a single asynchronous level, with a one-cycle
// pulse on each rising edge of the synchronised level.
module ipm_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/ipm_mcu_bus_master.sv
// MCU-side initiator for the ipm 8-bit bus: splits host word/byte commands into
// setup/strobe/hold bus cycles, sequences the bus reset and synchronises intMCU.
module ipm_mcu_bus_master
    import ipm_bus_pkg::*;
#(
    parameter int         STROBE_CYCLES = 2,
    parameter int         RESET_HOLD    = 4,
    parameter int         CONF_WIDTH    = 5,
    parameter logic [3:0] ADDR_DATA     = ADDR_DATA_DEF,
    parameter logic [3:0] ADDR_CONF     = ADDR_CONF_DEF,
    parameter logic [3:0] ADDR_START    = ADDR_START_DEF
) (
    input  logic        clk,
    input  logic        rst_a,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        mcu_rst_n,
    output logic [3:0]  mcu_addr,
    output logic        mcu_rd,
    output logic        mcu_wr,
    output logic [7:0]  mcu_data_o,
    output logic        mcu_data_oe,
    input  logic [7:0]  mcu_data_i,
    input  logic        mcu_int,
    output logic        irq_level,
    output logic        irq_pulse,
    output logic [2:0]  dbg_state
);

    // Command handshake: a command transfers on a clk edge where cmd_valid and
    // cmd_ready are both high; cmd_valid seen while cmd_ready is low is dropped.

    localparam int SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam int RCW = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;

    bus_state_e       r_state;
    bus_state_e       w_next;
    logic [1:0]       r_op;
    logic [31:0]      r_data;
    logic [31:0]      r_rd_buf;
    logic [31:0]      r_rsp_data;
    logic [1:0]       r_byte_idx;
    logic [SCW-1:0]   r_strb_cnt;
    logic [RCW-1:0]   r_rst_cnt;
    logic             r_mcu_rst_n;

    logic             w_accept;
    logic             w_last_strobe;
    logic             w_last_byte;
    logic             w_is_write;
    logic             w_in_access;
    logic [7:0]       w_conf_byte;
    logic [7:0]       w_wr_byte;
    logic [3:0]       w_addr;

    assign busy          = (r_state != ST_IDLE);
    assign cmd_ready     = ~busy & r_mcu_rst_n;
    assign w_accept      = cmd_valid & cmd_ready;
    assign w_last_strobe = (r_strb_cnt == SCW'(STROBE_CYCLES - 1));
    assign w_last_byte   = op_is_word(r_op) ? (r_byte_idx == 2'd3) : 1'b1;
    assign w_is_write    = (r_op != OP_READ_WORD);
    assign w_in_access   = (r_state == ST_SETUP) || (r_state == ST_STROBE) || (r_state == ST_HOLD);
    assign mcu_rst_n     = r_mcu_rst_n;
    assign rsp_data      = r_rsp_data;
    assign dbg_state     = r_state;

    always_comb begin
        w_conf_byte                 = '0;
        w_conf_byte[CONF_WIDTH-1:0] = r_data[CONF_WIDTH-1:0];
        w_wr_byte                   = '0;
        w_addr                      = '0;
        case (r_op)
            OP_WRITE_WORD: begin
                w_wr_byte = r_data[{r_byte_idx, 3'b000} +: 8];
                w_addr    = ADDR_DATA + {2'b00, r_byte_idx};
            end
            OP_READ_WORD:  w_addr = ADDR_DATA + {2'b00, r_byte_idx};
            OP_WRITE_CONF: begin
                w_wr_byte = w_conf_byte;
                w_addr    = ADDR_CONF;
            end
            default: begin
                w_wr_byte = START_BYTE;
                w_addr    = ADDR_START;
            end
        endcase
    end

    // Bus outputs decode straight from the async-reset state register, so an
    // rst_a mid-access drops strobes and oe without waiting for a clock edge.
    always_comb begin
        w_next      = r_state;
        mcu_rd      = 1'b0;
        mcu_wr      = 1'b0;
        mcu_data_oe = 1'b0;
        mcu_addr    = '0;
        mcu_data_o  = '0;
        rsp_valid   = 1'b0;
        if (w_in_access) begin
            mcu_addr    = w_addr;
            mcu_data_oe = w_is_write;
            mcu_data_o  = w_is_write ? w_wr_byte : 8'h00;
        end
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_STROBE;
            ST_STROBE: begin
                mcu_wr = w_is_write;
                mcu_rd = ~w_is_write;
                if (w_last_strobe) w_next = ST_HOLD;
            end
            ST_HOLD:   w_next = w_last_byte ? ST_DONE : ST_SETUP;
            ST_DONE: begin
                rsp_valid = 1'b1;
                w_next    = ST_IDLE;
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            r_state    <= ST_IDLE;
            r_op       <= '0;
            r_data     <= '0;
            r_rd_buf   <= '0;
            r_rsp_data <= '0;
            r_byte_idx <= '0;
            r_strb_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op       <= cmd_op;
                r_data     <= cmd_data;
                r_byte_idx <= '0;
            end
            if (r_state == ST_STROBE) begin
                r_strb_cnt <= w_last_strobe ? '0 : r_strb_cnt + SCW'(1);
                if (w_last_strobe && !w_is_write)
                    r_rd_buf[{r_byte_idx, 3'b000} +: 8] <= mcu_data_i;
            end
            if (r_state == ST_HOLD) begin
                if (!w_last_byte)
                    r_byte_idx <= r_byte_idx + 2'd1;
                else if (r_op == OP_READ_WORD)
                    r_rsp_data <= r_rd_buf;
            end
        end
    end

    // Bus-side reset stays low for RESET_HOLD full cycles after rst_a releases.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            r_rst_cnt   <= '0;
            r_mcu_rst_n <= 1'b0;
        end else if (!r_mcu_rst_n) begin
            if (r_rst_cnt == RCW'(RESET_HOLD))
                r_mcu_rst_n <= 1'b1;
            else
                r_rst_cnt <= r_rst_cnt + RCW'(1);
        end
    end

    ipm_sync2 u_int_sync (
        .i_clk   (clk),
        .i_rst   (rst_a),
        .i_async (mcu_int),
        .o_level (irq_level),
        .o_rise  (irq_pulse)
    );

endmodule

// File: tb/tb_ipm_mcu_bus_master.sv
// Directed bench for ipm_mcu_bus_master: command table with hand-computed
// latencies and read words, a bus monitor with expected-beat queue, and
// hand-written sequences for busy-ignore, mid-access reset and interrupts.
module tb_ipm_mcu_bus_master;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        mcu_rst_n;
    logic [3:0]  mcu_addr;
    logic        mcu_rd;
    logic        mcu_wr;
    logic [7:0]  mcu_data_o;
    logic        mcu_data_oe;
    logic [7:0]  mcu_data_i;
    logic        mcu_int = 1'b0;
    logic        irq_level;
    logic        irq_pulse;
    logic [2:0]  dbg_state;

    logic [7:0]  resp_mem [16];
    assign mcu_data_i = resp_mem[mcu_addr];

    ipm_mcu_bus_master dut (
        .clk(clk), .rst_a(rst_a), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .mcu_rst_n(mcu_rst_n), .mcu_addr(mcu_addr), .mcu_rd(mcu_rd),
        .mcu_wr(mcu_wr), .mcu_data_o(mcu_data_o), .mcu_data_oe(mcu_data_oe),
        .mcu_data_i(mcu_data_i), .mcu_int(mcu_int), .irq_level(irq_level),
        .irq_pulse(irq_pulse), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Beat record: {is_write, addr[3:0], data[7:0], strobe_len[3:0]}
    localparam int W = 17;
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beats(input logic [1:0] op, input logic [31:0] data);
        case (op)
            2'b00: for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 4'(k), data[8*k +: 8], 4'd2});
            2'b01: for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 4'(k), 8'h00, 4'd2});
            2'b10: exp_q.push_back({1'b1, 4'h4, 3'b000, data[4:0], 4'd2});
            default: exp_q.push_back({1'b1, 4'h5, 8'h01, 4'd2});
        endcase
    endtask

    // ---------------- bus monitor ----------------
    logic       mon_active = 1'b0;
    logic       mon_kind;
    logic [3:0] mon_addr;
    logic [7:0] mon_data;
    int         mon_len;

    always @(negedge clk) begin
        if (mcu_rd || mcu_wr) begin
            check("rd_wr_excl", 32'(mcu_rd & mcu_wr), 32'd0);
            check("oe_dir", 32'(mcu_data_oe), 32'(mcu_wr));
            if (!mon_active) begin
                mon_active = 1'b1;
                mon_kind   = mcu_wr;
                mon_addr   = mcu_addr;
                mon_data   = mcu_wr ? mcu_data_o : 8'h00;
                mon_len    = 1;
            end else begin
                check("addr_stable", 32'(mcu_addr), 32'(mon_addr));
                if (mcu_wr) check("data_stable", 32'(mcu_data_o), 32'(mon_data));
                mon_len++;
            end
        end else if (mon_active) begin
            mon_active = 1'b0;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL bus_beat_unexpected: got %h expected none", {mon_kind, mon_addr, mon_data, 4'(mon_len)});
            end else begin
                check("bus_beat", 32'({mon_kind, mon_addr, mon_data, 4'(mon_len)}), 32'(exp_q.pop_front()));
            end
        end
        if (!busy) check("oe_idle", 32'(mcu_data_oe), 32'd0);
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] op, input logic [31:0] data);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called at the negedge of cycle 1 after the accept edge.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic release_reset;
        @(negedge clk);
        rst_a = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("mcu_rst_n_seq", 32'(mcu_rst_n), 32'(k >= 5));
            check("cmd_ready_seq", 32'(cmd_ready), 32'(k >= 5));
            check("no_rsp_in_reset", 32'(rsp_valid), 32'd0);
        end
    endtask

    task automatic irq_watch(input int cycles, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            if (irq_pulse) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] rd_word;
        int          lat;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat;
        int pulses;
        int first;

        for (int a = 0; a < 16; a++) resp_mem[a] = 8'h00;

        vecs[0] = '{2'b00, 32'hA1B2_C3D4, 32'h0000_0000, 17, 32'h0000_0000};
        vecs[1] = '{2'b01, 32'h0000_0000, 32'h4433_2211, 17, 32'h4433_2211};
        vecs[2] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0000,  5, 32'h4433_2211};
        vecs[3] = '{2'b11, 32'h0000_0000, 32'h0000_0000,  5, 32'h4433_2211};
        vecs[4] = '{2'b00, 32'h00FF_5A01, 32'h0000_0000, 17, 32'h4433_2211};
        vecs[5] = '{2'b10, 32'h0000_00E6, 32'h0000_0000,  5, 32'h4433_2211};
        vecs[6] = '{2'b01, 32'h0000_0000, 32'hDEAD_BEEF, 17, 32'hDEAD_BEEF};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mcu_rst_n", 32'(mcu_rst_n), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_strobes", 32'({mcu_rd, mcu_wr, mcu_data_oe}), 32'd0);
        check("rst_irq", 32'({irq_level, irq_pulse}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        release_reset();

        // Table-driven commands
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 4; k++) resp_mem[k] = vecs[i].rd_word[8*k +: 8];
            push_beats(vecs[i].op, vecs[i].data);
            send(vecs[i].op, vecs[i].data);
            wait_rsp(lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_rsp_data", i), rsp_data, vecs[i].exp_rsp);
            check($sformatf("vec%0d_busy_done", i), 32'(busy), 32'd1);
            @(negedge clk);
            check($sformatf("vec%0d_busy_after", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d_rsp_pulse", i), 32'(rsp_valid), 32'd0);
        end

        // cmd_valid held with a different op during a busy WRITE_WORD
        for (int k = 0; k < 4; k++) resp_mem[k] = 8'h55 + 8'(k * 8'h11);
        push_beats(2'b00, 32'h1234_5678);
        push_beats(2'b01, 32'h0);
        send(2'b00, 32'h1234_5678);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        wait_rsp(lat);
        check("hold_wr_latency", 32'(lat), 32'd17);
        @(negedge clk);
        check("hold_idle_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        check("hold_rd_accepted", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        wait_rsp(lat);
        check("hold_rd_latency", 32'(lat), 32'd17);
        check("hold_rd_data", rsp_data, 32'h8877_6655);
        @(negedge clk);

        // rst_a in the first STROBE cycle of byte 2
        exp_q.push_back({1'b1, 4'h0, 8'hD4, 4'd2});
        exp_q.push_back({1'b1, 4'h1, 8'hC3, 4'd2});
        exp_q.push_back({1'b1, 4'h2, 8'hB2, 4'd1});
        send(2'b00, 32'hA1B2_C3D4);
        repeat (9) @(negedge clk);
        check("abort_wr_before", 32'({mcu_wr, mcu_addr}), 32'({1'b1, 4'h2}));
        #2 rst_a = 1'b1;
        #1;
        check("abort_wr_async", 32'({mcu_wr, mcu_rd, mcu_data_oe}), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
            check("abort_mcu_rst_n", 32'(mcu_rst_n), 32'd0);
        end
        release_reset();
        check("abort_rsp_data_cleared", rsp_data, 32'd0);

        // Interrupt while idle
        mcu_int = 1'b1;
        irq_watch(8, pulses, first);
        check("irq_idle_pulses", 32'(pulses), 32'd1);
        check("irq_idle_delay", 32'(first >= 2 && first <= 3), 32'd1);
        check("irq_level_high", 32'(irq_level), 32'd1);
        mcu_int = 1'b0;
        repeat (4) @(negedge clk);
        check("irq_level_low", 32'(irq_level), 32'd0);

        // Interrupt while busy with a START
        push_beats(2'b11, 32'h0);
        send(2'b11, 32'h0);
        mcu_int = 1'b1;
        irq_watch(8, pulses, first);
        check("irq_busy_pulses", 32'(pulses), 32'd1);
        check("irq_busy_delay", 32'(first >= 2 && first <= 3), 32'd1);

        repeat (3) @(negedge clk);
        check("beats_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
